// File: rtl/bank_pkg.sv
// Shared constants and types for the bank word sequencer and decoder.
package bank_pkg;

  localparam int BANK_ADDR_W = 10;
  localparam int BANK_WORDS  = 1 << BANK_ADDR_W;

  typedef logic [BANK_ADDR_W-1:0] bank_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } bank_state_t;

endpackage

// File: rtl/bank_addr_incr.sv
// Next word-select computation: wraps modulo the bank size or holds at the top word.
module bank_addr_incr #(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              wrap,
  output logic [ADDR_W-1:0] addr_next,
  output logic              at_top
);

  always_comb begin
    at_top    = (addr == {ADDR_W{1'b1}});
    addr_next = addr + 1'b1;
    if (at_top && !wrap)
      addr_next = addr;
  end

endmodule

// File: rtl/bank_word_sequencer.sv
// Burst address sequencer: one request per handshake, one sel per beat, plus one drain cycle.
//   state    | meaning
//   ST_IDLE  | waiting for a request, req_ready high
//   ST_RUN   | emitting beats, one per step_en
//   ST_DRAIN | decoder registers the final word; no live beat
module bank_word_sequencer
  import bank_pkg::*;
#(
  parameter int ADDR_W = BANK_ADDR_W,
  parameter int LEN_W  = BANK_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              req_write,
  input  logic              req_wrap,
  input  logic              step_en,
  output logic [ADDR_W-1:0] sel,
  output logic              sel_valid,
  output logic              sel_write,
  output logic              sel_last,
  output logic              busy,
  output logic              err_oob
);

  bank_state_t       state_q, state_d;
  logic [ADDR_W-1:0] sel_q;
  logic [ADDR_W-1:0] sel_next;
  logic [LEN_W-1:0]  beats_q;
  logic              wrap_q;
  logic              write_q;
  logic              err_q;
  logic              at_top;
  logic              accept;
  logic              advance;
  logic              last_beat;
  logic [ADDR_W:0]   span_end;

  bank_addr_incr #(.ADDR_W(ADDR_W)) u_incr (
    .addr      (sel_q),
    .wrap      (wrap_q),
    .addr_next (sel_next),
    .at_top    (at_top)
  );

  // One extra bit so addr+len past the top word is seen without overflow.
  assign span_end  = {1'b0, req_addr} + (ADDR_W+1)'(req_len);
  assign last_beat = (beats_q == '0) || (!wrap_q && at_top);
  assign accept    = (state_q == ST_IDLE) && req_valid;
  assign advance   = (state_q == ST_RUN) && step_en && !last_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_d = ST_RUN;
      end
      ST_RUN: begin
        sel_valid = 1'b1;
        sel_last  = last_beat;
        busy      = 1'b1;
        if (step_en && last_beat)
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= '0;
      beats_q <= '0;
      wrap_q  <= 1'b0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        sel_q   <= req_addr;
        beats_q <= req_len;
        wrap_q  <= req_wrap;
        write_q <= req_write;
        err_q   <= !req_wrap && (span_end > {1'b0, {ADDR_W{1'b1}}});
      end else if (advance) begin
        sel_q   <= sel_next;
        beats_q <= beats_q - 1'b1;
      end
    end
  end

  assign sel       = sel_q;
  assign sel_write = write_q;
  assign err_oob   = err_q;

endmodule

// File: tb/tb_bank_word_sequencer.sv
// Directed self-checking bench for bank_word_sequencer.
module tb_bank_word_sequencer;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_addr;
  logic [9:0] req_len;
  logic       req_write;
  logic       req_wrap;
  logic       step_en;
  logic [9:0] sel;
  logic       sel_valid;
  logic       sel_write;
  logic       sel_last;
  logic       busy;
  logic       err_oob;

  int n_checks = 0;
  int n_pass   = 0;

  bank_word_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_write (req_write),
    .req_wrap  (req_wrap),
    .step_en   (step_en),
    .sel       (sel),
    .sel_valid (sel_valid),
    .sel_write (sel_write),
    .sel_last  (sel_last),
    .busy      (busy),
    .err_oob   (err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request in IDLE; returns in the first cycle after the accept edge.
  task automatic start_req(input logic [9:0] a, input logic [9:0] l,
                           input logic w, input logic wr);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    req_write = w;
    req_wrap  = wr;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({req_ready, sel_valid, sel_last, busy, err_oob, sel_write} !== 6'b100000)
      $display("FAIL reset_flags: got %b expected 100000",
               {req_ready, sel_valid, sel_last, busy, err_oob, sel_write});
    else n_pass++;
    n_checks++;
    if (sel !== 10'd0) $display("FAIL reset_sel: got %0d expected 0", sel);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [9:0] e;
    step_en = 1'b1;
    start_req(10'd5, 10'd3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      e = 10'd5 + 10'(i);
      n_checks++;
      if (sel !== e || sel_valid !== 1'b1)
        $display("FAIL basic_sel%0d: got %0d/%b expected %0d/1", i, sel, sel_valid, e);
      else n_pass++;
      n_checks++;
      if (sel_last !== (i == 3) || err_oob !== 1'b0 || sel_write !== 1'b0)
        $display("FAIL basic_flags%0d: got last=%b err=%b wr=%b expected last=%b err=0 wr=0",
                 i, sel_last, err_oob, sel_write, (i == 3));
      else n_pass++;
      tick();
    end
    n_checks++;
    if (sel_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0 || sel !== 10'd8)
      $display("FAIL basic_drain: got v=%b busy=%b rdy=%b sel=%0d expected 0 1 0 8",
               sel_valid, busy, req_ready, sel);
    else n_pass++;
    tick();
    n_checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL basic_idle: got busy=%b rdy=%b expected 0 1", busy, req_ready);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [9:0] exp_sel [4];
    exp_sel[0] = 10'd1022;
    exp_sel[1] = 10'd1023;
    exp_sel[2] = 10'd0;
    exp_sel[3] = 10'd1;
    step_en = 1'b1;
    start_req(10'd1022, 10'd3, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (sel !== exp_sel[i] || sel_valid !== 1'b1 || sel_write !== 1'b1)
        $display("FAIL wrap_sel%0d: got %0d v=%b wr=%b expected %0d v=1 wr=1",
                 i, sel, sel_valid, sel_write, exp_sel[i]);
      else n_pass++;
      n_checks++;
      if (sel_last !== (i == 3) || err_oob !== 1'b0)
        $display("FAIL wrap_flags%0d: got last=%b err=%b expected last=%b err=0",
                 i, sel_last, err_oob, (i == 3));
      else n_pass++;
      tick();
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL wrap_idle: got busy=%b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_truncate();
    step_en = 1'b1;
    start_req(10'd1022, 10'd3, 1'b0, 1'b0);
    n_checks++;
    if (sel !== 10'd1022 || err_oob !== 1'b1 || sel_last !== 1'b0)
      $display("FAIL trunc_first: got sel=%0d err=%b last=%b expected 1022 1 0",
               sel, err_oob, sel_last);
    else n_pass++;
    tick();
    n_checks++;
    if (sel !== 10'd1023 || err_oob !== 1'b0 || sel_last !== 1'b1 || sel_valid !== 1'b1)
      $display("FAIL trunc_top: got sel=%0d err=%b last=%b v=%b expected 1023 0 1 1",
               sel, err_oob, sel_last, sel_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (sel_valid !== 1'b0 || sel !== 10'd1023 || busy !== 1'b1 || err_oob !== 1'b0)
      $display("FAIL trunc_drain: got v=%b sel=%0d busy=%b err=%b expected 0 1023 1 0",
               sel_valid, sel, busy, err_oob);
    else n_pass++;
    tick();
    n_checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL trunc_idle: got busy=%b rdy=%b expected 0 1", busy, req_ready);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [9:0] exp_sel [5];
    logic       exp_step [5];
    int         beats;
    exp_sel[0] = 10'd100; exp_step[0] = 1'b0;
    exp_sel[1] = 10'd100; exp_step[1] = 1'b0;
    exp_sel[2] = 10'd100; exp_step[2] = 1'b1;
    exp_sel[3] = 10'd101; exp_step[3] = 1'b1;
    exp_sel[4] = 10'd102; exp_step[4] = 1'b1;
    beats = 0;
    step_en = 1'b0;
    start_req(10'd100, 10'd2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step_en = exp_step[i];
      n_checks++;
      if (sel !== exp_sel[i] || sel_valid !== 1'b1 || sel_last !== (i == 4))
        $display("FAIL stall_sel%0d: got %0d v=%b last=%b expected %0d v=1 last=%b",
                 i, sel, sel_valid, sel_last, exp_sel[i], (i == 4));
      else n_pass++;
      if (sel_valid && step_en) beats++;
      tick();
    end
    if (sel_valid && step_en) beats++;
    n_checks++;
    if (beats !== 3) $display("FAIL stall_beats: got %0d expected 3", beats);
    else n_pass++;
    tick();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL stall_idle: got busy=%b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    step_en = 1'b1;
    start_req(10'd5, 10'd5, 1'b1, 1'b0);
    tick();
    tick();
    n_checks++;
    if (sel !== 10'd7 || sel_valid !== 1'b1)
      $display("FAIL rstmid_pre: got sel=%0d v=%b expected 7 1", sel, sel_valid);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (sel !== 10'd0 || sel_valid !== 1'b0 || busy !== 1'b0 || sel_last !== 1'b0 ||
        sel_write !== 1'b0)
      $display("FAIL rstmid_async: got sel=%0d v=%b busy=%b last=%b wr=%b expected 0 0 0 0 0",
               sel, sel_valid, busy, sel_last, sel_write);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || sel_valid !== 1'b0)
      $display("FAIL rstmid_release: got rdy=%b busy=%b v=%b expected 1 0 0",
               req_ready, busy, sel_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    step_en   = 1'b1;
    req_valid = 1'b1;
    req_addr  = 10'd10;
    req_len   = 10'd3;
    req_write = 1'b0;
    req_wrap  = 1'b0;
    tick();
    // Held request for the second burst changes while the first is running.
    req_addr = 10'd20;
    req_len  = 10'd0;
    for (int i = 0; i < 4; i++) begin
      e = 10'd10 + 10'(i);
      n_checks++;
      if (sel !== e || sel_valid !== 1'b1 || req_ready !== 1'b0)
        $display("FAIL b2b_first%0d: got sel=%0d v=%b rdy=%b expected %0d 1 0",
                 i, sel, sel_valid, req_ready, e);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (sel_valid !== 1'b0 || busy !== 1'b1 || sel !== 10'd13)
      $display("FAIL b2b_drain: got v=%b busy=%b sel=%0d expected 0 1 13",
               sel_valid, busy, sel);
    else n_pass++;
    tick();
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL b2b_idle: got rdy=%b busy=%b expected 1 0", req_ready, busy);
    else n_pass++;
    tick();
    req_valid = 1'b0;
    n_checks++;
    if (sel !== 10'd20 || sel_valid !== 1'b1 || sel_last !== 1'b1)
      $display("FAIL b2b_second: got sel=%0d v=%b last=%b expected 20 1 1",
               sel, sel_valid, sel_last);
    else n_pass++;
    tick();
    n_checks++;
    if (sel_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_second_drain: got v=%b busy=%b expected 0 1", sel_valid, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL b2b_end: got busy=%b rdy=%b expected 0 1", busy, req_ready);
    else n_pass++;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    req_write = 1'b0;
    req_wrap  = 1'b0;
    step_en   = 1'b0;
    #12;
    test_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    test_basic();
    test_wrap();
    test_truncate();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
